// File: rtl/data_mem_cache_sa_pkg.sv
// Shared encodings, sign_mask bit positions and default-derived widths for the data cache.
package data_mem_cache_sa_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        REFILL    = 2'd2,
        UPDATE    = 2'd3
    } cache_state_t;

    localparam int SM_SIGN = 3;
    localparam int SM_WORD = 2;
    localparam int SM_HALF = 1;

    localparam int DEF_WAYS       = 4;
    localparam int DEF_SETS       = 16;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_ADDR_W     = 14;

    localparam int OFFSET_W = $clog2(DEF_LINE_WORDS * 4);
    localparam int INDEX_W  = $clog2(DEF_SETS);
    localparam int TAG_W    = DEF_ADDR_W - OFFSET_W - INDEX_W;
    localparam int AGE_W    = (DEF_WAYS > 1) ? $clog2(DEF_WAYS) : 1;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/data_mem_cache_sa_lru.sv
// Per-set age tracker: hit-way select, victim choice (lowest invalid, else age 0) and LRU age update.
module cache_set_lru #(
    parameter int WAYS  = 4,
    parameter int WAY_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WAYS-1:0]  valid,
    input  logic [WAYS-1:0]  match,
    input  logic             touch,
    input  logic [WAY_W-1:0] touch_way,
    output logic             hit,
    output logic [WAY_W-1:0] hit_way,
    output logic [WAY_W-1:0] victim_way
);

    logic [WAY_W-1:0] age_r [WAYS];
    logic [WAY_W-1:0] old_age_s;
    logic [WAY_W-1:0] inv_way_s;
    logic [WAY_W-1:0] lru_way_s;
    logic             any_inv_s;

    // Hit detection and victim selection; descending loops leave the lowest way selected
    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        any_inv_s = 1'b0;
        inv_way_s = '0;
        lru_way_s = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit       = hit | (valid[w] & match[w]);
            hit_way   = (valid[w] & match[w]) ? WAY_W'(w) : hit_way;
            any_inv_s = any_inv_s | ~valid[w];
            inv_way_s = (!valid[w]) ? WAY_W'(w) : inv_way_s;
            lru_way_s = (age_r[w] == '0) ? WAY_W'(w) : lru_way_s;
        end
        victim_way = any_inv_s ? inv_way_s : lru_way_s;
        old_age_s  = age_r[touch_way];
    end

    // Age update: touched way becomes youngest, younger-than-it ways age by one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) age_r[w] <= WAY_W'(w);
        end else if (touch) begin
            for (int w = 0; w < WAYS; w++) begin
                if (WAY_W'(w) == touch_way) age_r[w] <= WAY_W'(WAYS - 1);
                else if (age_r[w] > old_age_s) age_r[w] <= age_r[w] - WAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/data_mem_cache_sa.sv
// N-way set-associative write-back/write-allocate data cache with uncached LED register.
// Optional CACHE_STATS_EN adds saturating hit/miss/writeback counters.
module data_mem_cache_sa
    import data_mem_cache_sa_pkg::*;
#(
    parameter int                WAYS       = 4,
    parameter int                SETS       = 16,
    parameter int                LINE_WORDS = 4,
    parameter int                ADDR_W     = 14,
    parameter logic [ADDR_W-1:0] LED_ADDR   = 14'h2000
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [ADDR_W-1:0]                     addr,
    input  logic [31:0]                           write_data,
    input  logic                                  memwrite,
    input  logic                                  memread,
    input  logic [3:0]                            sign_mask,
    output logic [31:0]                           read_data,
    output logic                                  clk_stall,
    output logic [7:0]                            led,
    output logic                                  mem_req,
    output logic                                  mem_we,
    output logic [ADDR_W-$clog2(LINE_WORDS*4)-1:0] mem_addr,
    output logic [32*LINE_WORDS-1:0]              mem_wdata,
    input  logic [32*LINE_WORDS-1:0]              mem_rdata,
    input  logic                                  mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                           stat_hits,
    output logic [31:0]                           stat_misses,
    output logic [31:0]                           stat_writebacks
`endif
);

    localparam int OFF_W  = $clog2(LINE_WORDS * 4);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TG_W   = ADDR_W - OFF_W - IDX_W;
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int WSEL_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int LINE_W = 32 * LINE_WORDS;

    function automatic logic [31:0] merge_store(input logic [31:0] old_word, input logic [31:0] wdata,
                                                input logic [1:0] byte_off, input logic [1:0] size);
        logic [31:0] res;
        res = old_word;
        if (size[1]) res = wdata;
        else if (size[0]) res[{byte_off[1], 4'b0000} +: 16] = wdata[15:0];
        else res[{byte_off, 3'b000} +: 8] = wdata[7:0];
        return res;
    endfunction

    // m = {sign, word, half}
    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] byte_off,
                                                 input logic [2:0] m);
        logic [15:0] h;
        logic [7:0]  b;
        h = word[{byte_off[1], 4'b0000} +: 16];
        b = word[{byte_off, 3'b000} +: 8];
        if (m[1]) return word;
        else if (m[0]) return {{16{m[2] & h[15]}}, h};
        else return {{24{m[2] & b[7]}}, b};
    endfunction

    cache_state_t      state_r;
    logic [LINE_W-1:0] data_r  [SETS][WAYS];
    logic [TG_W-1:0]   tag_r   [SETS][WAYS];
    logic [WAYS-1:0]   valid_r [SETS];
    logic [WAYS-1:0]   dirty_r [SETS];

    logic [ADDR_W-1:0] buf_addr_r;
    logic [31:0]       buf_wdata_r;
    logic              buf_we_r;
    logic [2:0]        buf_mask_r;
    logic [WAY_W-1:0]  victim_r;
    logic [LINE_W-1:0] line_buf_r;
    logic [7:0]        led_r;

    logic              req_s, is_led_s, hit_s;
    logic [IDX_W-1:0]  req_idx_s, buf_idx_s, touch_set_s, wr_set_s;
    logic [TG_W-1:0]   req_tag_s, buf_tag_s;
    logic [WSEL_W-1:0] req_wsel_s, buf_wsel_s;
    logic [WAY_W-1:0]  hit_way_s, victim_s, touch_way_s, wr_way_s;
    logic [LINE_W-1:0] hit_line_s, wr_line_s;
    logic [31:0]       hit_word_s, fill_word_s;
    logic              touch_en_s, wr_en_s, wr_tag_s;
    logic              set_hit_s    [SETS];
    logic [WAY_W-1:0]  set_hit_way_s[SETS];
    logic [WAY_W-1:0]  set_victim_s [SETS];
    logic              unused_ok_s;

    assign req_s       = (memread | memwrite) & (state_r == IDLE);
    assign is_led_s    = (addr == LED_ADDR);
    assign req_idx_s   = addr[OFF_W +: IDX_W];
    assign req_tag_s   = addr[OFF_W+IDX_W +: TG_W];
    assign req_wsel_s  = WSEL_W'((addr >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign buf_idx_s   = buf_addr_r[OFF_W +: IDX_W];
    assign buf_tag_s   = buf_addr_r[OFF_W+IDX_W +: TG_W];
    assign buf_wsel_s  = WSEL_W'((buf_addr_r >> 2) & ADDR_W'(LINE_WORDS - 1));
    assign hit_s       = set_hit_s[req_idx_s];
    assign hit_way_s   = set_hit_way_s[req_idx_s];
    assign victim_s    = set_victim_s[req_idx_s];
    assign hit_line_s  = data_r[req_idx_s][hit_way_s];
    assign hit_word_s  = hit_line_s[{req_wsel_s, 5'b00000} +: 32];
    assign fill_word_s = line_buf_r[{buf_wsel_s, 5'b00000} +: 32];
    assign led         = led_r;
    assign unused_ok_s = sign_mask[0];

    for (genvar s = 0; s < SETS; s++) begin : g_set
        logic [WAYS-1:0] tag_eq_s;

        // Tag comparison for every way of this set against the incoming request
        always_comb begin
            tag_eq_s = '0;
            for (int w = 0; w < WAYS; w++) tag_eq_s[w] = (tag_r[s][w] == req_tag_s);
        end

        cache_set_lru #(.WAYS(WAYS), .WAY_W(WAY_W)) u_lru (
            .clk        (clk),
            .rst_n      (rst_n),
            .valid      (valid_r[s]),
            .match      (tag_eq_s),
            .touch      (touch_en_s && (touch_set_s == IDX_W'(s))),
            .touch_way  (touch_way_s),
            .hit        (set_hit_s[s]),
            .hit_way    (set_hit_way_s[s]),
            .victim_way (set_victim_s[s])
        );
    end

    // LRU touch on a cached hit or on the fill cycle
    always_comb begin
        touch_en_s  = 1'b0;
        touch_set_s = req_idx_s;
        touch_way_s = hit_way_s;
        if (req_s && !is_led_s && hit_s) begin
            touch_en_s = 1'b1;
        end else if (state_r == UPDATE) begin
            touch_en_s  = 1'b1;
            touch_set_s = buf_idx_s;
            touch_way_s = victim_r;
        end else begin
            touch_en_s = 1'b0;
        end
    end

    // Line write source: store hit merges into the cached line, fill merges the pending store
    always_comb begin
        wr_en_s   = 1'b0;
        wr_tag_s  = 1'b0;
        wr_set_s  = req_idx_s;
        wr_way_s  = hit_way_s;
        wr_line_s = hit_line_s;
        if (req_s && !is_led_s && hit_s && memwrite) begin
            wr_en_s = 1'b1;
            wr_line_s[{req_wsel_s, 5'b00000} +: 32] =
                merge_store(hit_word_s, write_data, addr[1:0], sign_mask[2:1]);
        end else if (state_r == UPDATE) begin
            wr_en_s   = 1'b1;
            wr_tag_s  = 1'b1;
            wr_set_s  = buf_idx_s;
            wr_way_s  = victim_r;
            wr_line_s = line_buf_r;
            if (buf_we_r) begin
                wr_line_s[{buf_wsel_s, 5'b00000} +: 32] =
                    merge_store(fill_word_s, buf_wdata_r, buf_addr_r[1:0], buf_mask_r[1:0]);
            end else begin
                wr_line_s = line_buf_r;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Line data and tag storage (contents meaningless until valid is set)
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            data_r[wr_set_s][wr_way_s] <= wr_line_s;
            if (wr_tag_s) tag_r[wr_set_s][wr_way_s] <= buf_tag_s;
        end
    end

    // Miss-handling FSM with registered outputs, valid/dirty bits and request buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            read_data   <= 32'd0;
            clk_stall   <= 1'b0;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            led_r       <= 8'd0;
            buf_addr_r  <= '0;
            buf_wdata_r <= 32'd0;
            buf_we_r    <= 1'b0;
            buf_mask_r  <= 3'd0;
            victim_r    <= '0;
            line_buf_r  <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_r[s] <= '0;
                dirty_r[s] <= '0;
            end
`ifdef CACHE_STATS_EN
            stat_hits       <= 32'd0;
            stat_misses     <= 32'd0;
            stat_writebacks <= 32'd0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_s) begin
                        if (is_led_s) begin
                            if (memwrite) led_r <= write_data[7:0];
                            else read_data <= 32'd0;
                        end else if (hit_s) begin
                            if (memwrite) dirty_r[req_idx_s][hit_way_s] <= 1'b1;
                            else read_data <= load_extract(hit_word_s, addr[1:0], sign_mask[3:1]);
`ifdef CACHE_STATS_EN
                            stat_hits <= sat_inc(stat_hits);
`endif
                        end else begin
                            buf_addr_r  <= addr;
                            buf_wdata_r <= write_data;
                            buf_we_r    <= memwrite;
                            buf_mask_r  <= sign_mask[3:1];
                            victim_r    <= victim_s;
                            mem_wdata   <= data_r[req_idx_s][victim_s];
                            clk_stall   <= 1'b1;
                            mem_req     <= 1'b1;
                            if (valid_r[req_idx_s][victim_s] && dirty_r[req_idx_s][victim_s]) begin
                                state_r  <= WRITEBACK;
                                mem_we   <= 1'b1;
                                mem_addr <= {tag_r[req_idx_s][victim_s], req_idx_s};
                            end else begin
                                state_r  <= REFILL;
                                mem_we   <= 1'b0;
                                mem_addr <= addr[ADDR_W-1:OFF_W];
                            end
`ifdef CACHE_STATS_EN
                            stat_misses <= sat_inc(stat_misses);
`endif
                        end
                    end
                end
                WRITEBACK: begin
                    if (mem_ack) begin
                        state_r  <= REFILL;
                        mem_we   <= 1'b0;
                        mem_addr <= buf_addr_r[ADDR_W-1:OFF_W];
`ifdef CACHE_STATS_EN
                        stat_writebacks <= sat_inc(stat_writebacks);
`endif
                    end
                end
                REFILL: begin
                    if (mem_ack) begin
                        line_buf_r <= mem_rdata;
                        mem_req    <= 1'b0;
                        state_r    <= UPDATE;
                    end
                end
                UPDATE: begin
                    valid_r[buf_idx_s][victim_r] <= 1'b1;
                    dirty_r[buf_idx_s][victim_r] <= buf_we_r;
                    if (!buf_we_r) read_data <= load_extract(fill_word_s, buf_addr_r[1:0], buf_mask_r);
                    clk_stall <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    clk_stall <= 1'b0;
                    mem_req   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_cache_sa.sv
// Directed self-checking bench for data_mem_cache_sa (default build, 4 ways x 16 sets x 4 words).
module tb_data_mem_cache_sa;

    logic         clk;
    logic         rst_n;
    logic [13:0]  addr;
    logic [31:0]  write_data;
    logic         memwrite;
    logic         memread;
    logic [3:0]   sign_mask;
    logic [31:0]  read_data;
    logic         clk_stall;
    logic [7:0]   led;
    logic         mem_req;
    logic         mem_we;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;
`ifdef CACHE_STATS_EN
    logic [31:0]  stat_hits, stat_misses, stat_writebacks;
`endif

    int n_total = 0;
    int n_bad   = 0;

    data_mem_cache_sa dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .addr       (addr),
        .write_data (write_data),
        .memwrite   (memwrite),
        .memread    (memread),
        .sign_mask  (sign_mask),
        .read_data  (read_data),
        .clk_stall  (clk_stall),
        .led        (led),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
        ,
        .stat_hits       (stat_hits),
        .stat_misses     (stat_misses),
        .stat_writebacks (stat_writebacks)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Load that misses on a clean victim; refill line is w0, w0+1, w0+2, w0+3
    task automatic miss_load(input string tag, input logic [13:0] a, input logic [3:0] m,
                             input logic [31:0] w0, input logic [9:0] la, input logic [31:0] exp);
        addr = a; sign_mask = m; memread = 1'b1;
        tick();
        memread = 1'b0;
        check_eq({tag, "_stall"}, clk_stall, 1'b1);
        check_eq({tag, "_req"}, mem_req, 1'b1);
        check_eq({tag, "_we"}, mem_we, 1'b0);
        check_eq({tag, "_maddr"}, mem_addr, la);
        tick();
        tick();
        check_eq({tag, "_req_held"}, mem_req, 1'b1);
        mem_rdata = {w0 + 32'd3, w0 + 32'd2, w0 + 32'd1, w0};
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq({tag, "_req_drop"}, mem_req, 1'b0);
        check_eq({tag, "_stall_upd"}, clk_stall, 1'b1);
        tick();
        check_eq({tag, "_stall_end"}, clk_stall, 1'b0);
        check_eq({tag, "_rdata"}, read_data, exp);
    endtask

    task automatic hit_access(input string tag, input logic [13:0] a, input logic [3:0] m,
                              input logic we, input logic [31:0] wd, input logic [31:0] exp);
        addr = a; sign_mask = m; memwrite = we; memread = ~we; write_data = wd;
        tick();
        memwrite = 1'b0; memread = 1'b0;
        check_eq({tag, "_stall"}, clk_stall, 1'b0);
        check_eq({tag, "_req"}, mem_req, 1'b0);
        if (!we) check_eq({tag, "_rdata"}, read_data, exp);
    endtask

    initial begin
        rst_n = 1'b0; addr = 14'd0; write_data = 32'd0; memwrite = 1'b0; memread = 1'b0;
        sign_mask = 4'd0; mem_rdata = 128'd0; mem_ack = 1'b0;
        #12;
        check_eq("rst_rdata", read_data, 32'd0);
        check_eq("rst_stall", clk_stall, 1'b0);
        check_eq("rst_req", mem_req, 1'b0);
        check_eq("rst_we", mem_we, 1'b0);
        check_eq("rst_led", led, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Cold miss fills way 0 of set 0, then byte and half-word hits
        miss_load("ld100", 14'h0100, 4'b0110, 32'hDEADBEEF, 10'h010, 32'hDEADBEEF);
        hit_access("ldb_s", 14'h0100, 4'b1000, 1'b0, 32'd0, 32'hFFFFFFEF);
        hit_access("sth", 14'h0102, 4'b0010, 1'b1, 32'h00001234, 32'd0);
        hit_access("ldw", 14'h0100, 4'b0110, 1'b0, 32'd0, 32'h1234BEEF);

        // Fill remaining ways of set 0 with assorted load sizes
        miss_load("ld200", 14'h0200, 4'b0110, 32'h11112222, 10'h020, 32'h11112222);
        miss_load("ld303", 14'h0303, 4'b0000, 32'h8899AABB, 10'h030, 32'h00000088);
        miss_load("ld402", 14'h0402, 4'b1010, 32'hF00D1111, 10'h040, 32'hFFFFF00D);

        // Fifth tag evicts the dirty LRU line (0x0100) through writeback
        addr = 14'h0504; sign_mask = 4'b0110; memread = 1'b1;
        tick();
        memread = 1'b0;
        check_eq("wb_stall", clk_stall, 1'b1);
        check_eq("wb_req", mem_req, 1'b1);
        check_eq("wb_we", mem_we, 1'b1);
        check_eq("wb_maddr", mem_addr, 10'h010);
        check_eq("wb_w0", mem_wdata[31:0], 32'h1234BEEF);
        check_eq("wb_w1", mem_wdata[63:32], 32'hDEADBEF0);
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("rf_req", mem_req, 1'b1);
        check_eq("rf_we", mem_we, 1'b0);
        check_eq("rf_maddr", mem_addr, 10'h050);
        mem_rdata = {32'h55550003, 32'h55550002, 32'h55550001, 32'h55550000};
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("rf_stall_upd", clk_stall, 1'b1);
        tick();
        check_eq("rf_stall_end", clk_stall, 1'b0);
        check_eq("rf_rdata", read_data, 32'h55550001);
        hit_access("ld500", 14'h0500, 4'b0110, 1'b0, 32'd0, 32'h55550000);

        // LED register is uncached and never stalls; stray ack in IDLE is ignored
        hit_access("led_st", 14'h2000, 4'b0110, 1'b1, 32'h000000A5, 32'd0);
        check_eq("led_val", led, 8'hA5);
        hit_access("led_ld", 14'h2000, 4'b0110, 1'b0, 32'd0, 32'd0);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check_eq("ack_idle_stall", clk_stall, 1'b0);
        check_eq("ack_idle_req", mem_req, 1'b0);

        // Reset during a refill wait aborts the miss at once
        addr = 14'h0100; sign_mask = 4'b0110; memread = 1'b1;
        tick();
        memread = 1'b0;
        check_eq("mid_req", mem_req, 1'b1);
        tick();
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_req", mem_req, 1'b0);
        check_eq("mid_rst_stall", clk_stall, 1'b0);
        check_eq("mid_rst_led", led, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();
        miss_load("post_rst", 14'h0100, 4'b0110, 32'hCAFE0000, 10'h010, 32'hCAFE0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
